// File: rtl/axi_fifo_slave.sv
// axi_fifo_slave: AXI4 burst slave backed by one FIFO queue instead of memory.
// Write beats push, read beats pop the oldest word; addresses and burst attributes are ignored.
module axi_fifo_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH/8,
    parameter int DEPTH      = 16
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic [ADDR_WIDTH-1:0]    AWADDR,
    input  logic [7:0]               AWLEN,
    input  logic [2:0]               AWSIZE,
    input  logic [1:0]               AWBURST,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [DATA_WIDTH-1:0]    WDATA,
    input  logic [STRB_WIDTH-1:0]    WSTRB,
    input  logic                     WLAST,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic [1:0]               BRESP,
    output logic                     BVALID,
    input  logic                     BREADY,
    input  logic [ADDR_WIDTH-1:0]    ARADDR,
    input  logic [7:0]               ARLEN,
    input  logic [2:0]               ARSIZE,
    input  logic [1:0]               ARBURST,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    output logic [DATA_WIDTH-1:0]    RDATA,
    output logic [1:0]               RRESP,
    output logic                     RLAST,
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]        wr_ptr, rd_ptr;
    logic                  full, empty, push, pop, w_beat;
    logic                  out_of_reset;
    logic [1:0]            w_state;
    logic [7:0]            w_len, w_cnt;
    logic                  w_err;
    logic [0:0]            r_state;
    logic [7:0]            r_len, r_cnt;
    logic                  unused_inputs;

    assign unused_inputs = ^{AWADDR, AWSIZE, AWBURST, ARADDR, ARSIZE, ARBURST};

    assign full       = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign empty      = (wr_ptr == rd_ptr);
    assign fifo_count = wr_ptr - rd_ptr;

    // Ready outputs stay low until the first edge after reset release.
    assign AWREADY = out_of_reset && (w_state == W_IDLE);
    assign WREADY  = (w_state == W_DATA) && !full;
    assign BVALID  = (w_state == W_RESP);
    assign BRESP   = {BVALID && w_err, 1'b0};
    assign w_beat  = WVALID && WREADY;
    assign push    = w_beat && (WSTRB == '1);

    // An empty FIFO answers with SLVERR and zero data rather than stalling the read.
    assign ARREADY = out_of_reset && (r_state == R_IDLE);
    assign RVALID  = (r_state == R_DATA);
    assign RLAST   = RVALID && (r_cnt == r_len);
    assign RDATA   = (RVALID && !empty) ? mem[rd_ptr[PTR_W-1:0]] : '0;
    assign RRESP   = (RVALID && empty) ? 2'b10 : 2'b00;
    assign pop     = RVALID && RREADY && !empty;

    always_ff @(posedge ACLK) begin
        if (push)
            mem[wr_ptr[PTR_W-1:0]] <= WDATA;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            out_of_reset <= 1'b0;
            w_state      <= W_IDLE;
            w_len        <= '0;
            w_cnt        <= '0;
            w_err        <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
            case (w_state)
                W_IDLE: begin
                    if (AWVALID && AWREADY) begin
                        w_len   <= AWLEN;
                        w_cnt   <= '0;
                        w_err   <= 1'b0;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        if ((WSTRB != '1) || (WLAST != (w_cnt == w_len)))
                            w_err <= 1'b1;
                        if (w_cnt == w_len)
                            w_state <= W_RESP;
                        else
                            w_cnt <= w_cnt + 8'd1;
                    end
                end
                W_RESP: begin
                    if (BREADY)
                        w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= R_IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ARVALID && ARREADY) begin
                        r_len   <= ARLEN;
                        r_cnt   <= '0;
                        r_state <= R_DATA;
                    end
                end
                default: begin
                    if (RREADY) begin
                        if (r_cnt == r_len)
                            r_state <= R_IDLE;
                        else
                            r_cnt <= r_cnt + 8'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_fifo_slave.sv
// Testbench for axi_fifo_slave: directed scenarios plus randomized bursts
// checked against a queue-based model of the mailbox.
module tb_axi_fifo_slave;
    localparam int DW = 32, AW = 16, SW = 4, DEPTH = 16;

    logic ACLK = 1'b0, ARESETn = 1'b0;
    logic [AW-1:0] AWADDR = '0, ARADDR = '0;
    logic [7:0] AWLEN = '0, ARLEN = '0;
    logic [2:0] AWSIZE = '0, ARSIZE = '0;
    logic [1:0] AWBURST = '0, ARBURST = '0, BRESP, RRESP;
    logic AWVALID = 1'b0, AWREADY, WLAST = 1'b0, WVALID = 1'b0, WREADY;
    logic BVALID, BREADY = 1'b0, ARVALID = 1'b0, ARREADY, RLAST, RVALID, RREADY = 1'b0;
    logic [DW-1:0] WDATA = '0, RDATA;
    logic [SW-1:0] WSTRB = '0;
    logic [$clog2(DEPTH):0] fifo_count;

    always #5 ACLK = ~ACLK;

    axi_fifo_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .DEPTH(DEPTH)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .fifo_count(fifo_count)
    );

    int tests_run = 0, tests_failed = 0;
    logic [DW-1:0] model_q[$];

    logic [DW-1:0] w_data[256];
    logic [SW-1:0] w_strb[256];
    logic          w_last[256];
    logic [DW-1:0] r_obs_data[256], r_exp_data[256];
    logic [1:0]    r_obs_resp[256], r_exp_resp[256];
    logic          r_obs_last[256], r_exp_last[256];
    int r_beats, w_beats, w_stall_beat, max_cnt, cnt_err;
    int aw_cyc, w_first_cyc, w_last_cyc, b_first_cyc, ar_cyc, r_first_cyc;
    logic [1:0] bresp_obs;

    task automatic fill_write(input int len);
        for (int i = 0; i <= len; i++) begin
            w_data[i] = $urandom;
            w_strb[i] = '1;
            w_last[i] = (i == len);
        end
    endtask

    // Expected write response from the stimulus itself: any partial strobe or misplaced WLAST is an error.
    function automatic logic [1:0] exp_bresp(input int len);
        for (int i = 0; i <= len; i++)
            if (w_strb[i] != '1 || w_last[i] != (i == len)) return 2'b10;
        return 2'b00;
    endfunction

    // Cycle-stepped bus driver; records observations and model-derived expectations.
    task automatic bus_run(input bit do_w, input int wlen, input bit do_r, input int rlen,
                           input int r_delay, input int r_stall_pct, input int b_delay);
        int wph = do_w ? 0 : 3;
        int rph = do_r ? 0 : 2;
        int cyc = 0, bwait = 0, wb = 0, rb = 0;
        bit timed_out = 1'b0;
        w_beats = 0; r_beats = 0; w_stall_beat = -1; max_cnt = 0; cnt_err = 0;
        aw_cyc = -1; w_first_cyc = -1; w_last_cyc = -1; b_first_cyc = -1;
        ar_cyc = -1; r_first_cyc = -1; bresp_obs = 2'b11;
        while (wph != 3 || rph != 2) begin
            @(posedge ACLK); #1;
            cyc++;
            if (cyc > 2000) begin timed_out = 1'b1; break; end
            if (fifo_count != model_q.size()) cnt_err++;
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
            // Read side first: it sees the queue as it stood before this cycle's push.
            case (rph)
                0: if (cyc > r_delay) begin
                    ARVALID = 1; ARLEN = rlen[7:0]; ARADDR = AW'($urandom);
                    ARBURST = 2'($urandom); ARSIZE = 3'd2;
                    if (ARREADY) begin rph = 1; ar_cyc = cyc; end
                end
                1: begin
                    if (RVALID && r_first_cyc < 0) r_first_cyc = cyc;
                    RREADY = ($urandom_range(0, 99) >= r_stall_pct);
                    if (RVALID && RREADY) begin
                        r_obs_data[rb] = RDATA; r_obs_resp[rb] = RRESP; r_obs_last[rb] = RLAST;
                        if (model_q.size() > 0) begin
                            r_exp_data[rb] = model_q.pop_front(); r_exp_resp[rb] = 2'b00;
                        end else begin
                            r_exp_data[rb] = '0; r_exp_resp[rb] = 2'b10;
                        end
                        r_exp_last[rb] = (rb == rlen);
                        rb++; r_beats = rb;
                        if (rb == rlen + 1) rph = 2;
                    end
                end
                default: ;
            endcase
            case (wph)
                0: begin
                    AWVALID = 1; AWLEN = wlen[7:0]; AWADDR = AW'($urandom);
                    AWBURST = 2'($urandom); AWSIZE = 3'd2;
                    if (AWREADY) begin wph = 1; aw_cyc = cyc; end
                end
                1: begin
                    WVALID = 1; WDATA = w_data[wb]; WSTRB = w_strb[wb]; WLAST = w_last[wb];
                    if (WREADY) begin
                        if (w_first_cyc < 0) w_first_cyc = cyc;
                        w_last_cyc = cyc;
                        if (w_strb[wb] == '1) model_q.push_back(w_data[wb]);
                        wb++; w_beats = wb;
                        if (wb == wlen + 1) wph = 2;
                    end else if (w_stall_beat < 0) w_stall_beat = wb;
                end
                2: begin
                    if (BVALID && b_first_cyc < 0) b_first_cyc = cyc;
                    BREADY = (bwait >= b_delay); bwait++;
                    if (BVALID && BREADY) begin bresp_obs = BRESP; wph = 3; end
                end
                default: ;
            endcase
        end
        @(posedge ACLK); #1;
        AWVALID = 0; WVALID = 0; WLAST = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
        tests_run++;
        if (timed_out) begin
            tests_failed++;
            $display("FAIL bus_timeout: got wbeats=%0d rbeats=%0d want burst completion", wb, rb);
        end
    endtask

    task automatic test_reset();
        ARESETn = 0;
        repeat (2) @(posedge ACLK);
        #1;
        tests_run++;
        if ({AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RLAST} !== 10'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b want 0", {AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RLAST});
        end
        tests_run++;
        if (RDATA !== '0 || fifo_count !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: got rdata=%h count=%0d want 0 0", RDATA, fifo_count);
        end
        @(negedge ACLK); ARESETn = 1; #1;
        tests_run++;
        if (AWREADY !== 1'b0 || ARREADY !== 1'b0) begin
            tests_failed++;
            $display("FAIL ready_before_edge: got aw=%b ar=%b want 0 0", AWREADY, ARREADY);
        end
        @(posedge ACLK); #1;
        tests_run++;
        if (AWREADY !== 1'b1 || ARREADY !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_after_edge: got aw=%b ar=%b want 1 1", AWREADY, ARREADY);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) begin
            w_data[i] = DW'(32'h11 * (i + 1)); w_strb[i] = '1; w_last[i] = (i == 3);
        end
        bus_run(1, 3, 0, 0, 0, 0, 0);
        tests_run++;
        if (bresp_obs !== 2'b00 || fifo_count !== 5'd4) begin
            tests_failed++;
            $display("FAIL basic_write: got bresp=%b count=%0d want 00 4", bresp_obs, fifo_count);
        end
        tests_run++;
        if (w_first_cyc - aw_cyc != 1 || w_last_cyc - w_first_cyc != 3 || b_first_cyc - w_last_cyc != 1) begin
            tests_failed++;
            $display("FAIL basic_wtiming: got gaps %0d %0d %0d want 1 3 1",
                     w_first_cyc - aw_cyc, w_last_cyc - w_first_cyc, b_first_cyc - w_last_cyc);
        end
        tests_run++;
        if (AWREADY !== 1'b1) begin
            tests_failed++;
            $display("FAIL awready_after_b: got %b want 1", AWREADY);
        end
        bus_run(0, 0, 1, 3, 0, 0, 0);
        tests_run++;
        if (r_beats != 4 || r_first_cyc - ar_cyc != 1 || fifo_count !== '0) begin
            tests_failed++;
            $display("FAIL basic_read: got beats=%0d gap=%0d count=%0d want 4 1 0",
                     r_beats, r_first_cyc - ar_cyc, fifo_count);
        end
        for (int i = 0; i < r_beats; i++) begin
            tests_run++;
            if (r_obs_data[i] !== DW'(32'h11 * (i + 1)) || r_obs_resp[i] !== 2'b00 || r_obs_last[i] !== (i == 3)) begin
                tests_failed++;
                $display("FAIL basic_rbeat%0d: got %h/%b/%b want %h/00/%b", i, r_obs_data[i],
                         r_obs_resp[i], r_obs_last[i], DW'(32'h11 * (i + 1)), (i == 3));
            end
        end
    endtask

    task automatic test_empty_read();
        bus_run(0, 0, 1, 1, 0, 0, 0);
        tests_run++;
        if (r_beats != 2) begin
            tests_failed++;
            $display("FAIL empty_beats: got %0d want 2", r_beats);
        end
        for (int i = 0; i < r_beats; i++) begin
            tests_run++;
            if (r_obs_data[i] !== '0 || r_obs_resp[i] !== 2'b10 || r_obs_last[i] !== (i == 1)) begin
                tests_failed++;
                $display("FAIL empty_rbeat%0d: got %h/%b/%b want 0/10/%b", i, r_obs_data[i],
                         r_obs_resp[i], r_obs_last[i], (i == 1));
            end
        end
    endtask

    task automatic test_bad_write();
        fill_write(1);
        w_strb[0] = 4'b0111;
        bus_run(1, 1, 0, 0, 0, 0, 0);
        tests_run++;
        if (bresp_obs !== 2'b10 || fifo_count !== 5'd1) begin
            tests_failed++;
            $display("FAIL bad_strb: got bresp=%b count=%0d want 10 1", bresp_obs, fifo_count);
        end
        bus_run(0, 0, 1, 0, 0, 0, 0);
        tests_run++;
        if (r_obs_data[0] !== w_data[1] || r_obs_resp[0] !== 2'b00) begin
            tests_failed++;
            $display("FAIL bad_strb_data: got %h/%b want %h/00", r_obs_data[0], r_obs_resp[0], w_data[1]);
        end
        fill_write(1);
        w_last[0] = 1'b1; w_last[1] = 1'b0;
        bus_run(1, 1, 0, 0, 0, 0, 2);
        tests_run++;
        if (bresp_obs !== 2'b10 || fifo_count !== 5'd2 || w_beats != 2) begin
            tests_failed++;
            $display("FAIL early_wlast: got bresp=%b count=%0d beats=%0d want 10 2 2", bresp_obs, fifo_count, w_beats);
        end
        bus_run(0, 0, 1, 1, 0, 0, 0);
    endtask

    task automatic test_overlap();
        logic [DW-1:0] pre0, pre1, exp_d;
        fill_write(1);
        pre0 = w_data[0]; pre1 = w_data[1];
        bus_run(1, 1, 0, 0, 0, 0, 0);
        fill_write(7);
        bus_run(1, 7, 1, 7, 0, 0, 0);
        tests_run++;
        if (max_cnt > 3 || bresp_obs !== 2'b00 || fifo_count !== 5'd2) begin
            tests_failed++;
            $display("FAIL overlap_stat: got max=%0d bresp=%b count=%0d want <=3 00 2", max_cnt, bresp_obs, fifo_count);
        end
        for (int i = 0; i < r_beats; i++) begin
            exp_d = (i == 0) ? pre0 : (i == 1) ? pre1 : w_data[i-2];
            tests_run++;
            if (r_obs_data[i] !== exp_d || r_obs_resp[i] !== 2'b00) begin
                tests_failed++;
                $display("FAIL overlap_rbeat%0d: got %h/%b want %h/00", i, r_obs_data[i], r_obs_resp[i], exp_d);
            end
        end
        bus_run(0, 0, 1, 1, 0, 0, 0);
    endtask

    task automatic test_overflow();
        fill_write(19);
        bus_run(1, 19, 1, 3, 30, 0, 0);
        tests_run++;
        if (w_stall_beat != DEPTH || max_cnt != DEPTH || w_beats != 20 || bresp_obs !== 2'b00) begin
            tests_failed++;
            $display("FAIL overflow: got stall=%0d max=%0d beats=%0d bresp=%b want 16 16 20 00",
                     w_stall_beat, max_cnt, w_beats, bresp_obs);
        end
        for (int i = 0; i < r_beats; i++) begin
            tests_run++;
            if (r_obs_data[i] !== w_data[i]) begin
                tests_failed++;
                $display("FAIL overflow_rbeat%0d: got %h want %h", i, r_obs_data[i], w_data[i]);
            end
        end
        bus_run(0, 0, 1, 15, 0, 30, 0);
        tests_run++;
        if (fifo_count !== '0 || cnt_err != 0) begin
            tests_failed++;
            $display("FAIL drain_count: got count=%0d cnt_err=%0d want 0 0", fifo_count, cnt_err);
        end
        for (int i = 0; i < r_beats; i++) begin
            tests_run++;
            if (r_obs_data[i] !== w_data[i+4] || r_obs_resp[i] !== 2'b00) begin
                tests_failed++;
                $display("FAIL drain_rbeat%0d: got %h/%b want %h/00", i, r_obs_data[i], r_obs_resp[i], w_data[i+4]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int n = 0;
        @(posedge ACLK); #1;
        AWVALID = 1; AWLEN = 8'd3;
        while (!AWREADY && n < 20) begin @(posedge ACLK); #1; n++; end
        @(posedge ACLK); #1;
        AWVALID = 0; WVALID = 1; WDATA = $urandom; WSTRB = '1; WLAST = 0;
        @(posedge ACLK); #1;
        tests_run++;
        if (fifo_count !== 5'd1) begin
            tests_failed++;
            $display("FAIL midrst_beat1: got count=%0d want 1", fifo_count);
        end
        WDATA = $urandom;
        #2 ARESETn = 0;
        #1;
        tests_run++;
        if ({AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RLAST} !== 10'b0 ||
            RDATA !== '0 || fifo_count !== '0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got ctrl=%b rdata=%h count=%0d want 0",
                     {AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RLAST}, RDATA, fifo_count);
        end
        WVALID = 0;
        model_q.delete();
        @(negedge ACLK); ARESETn = 1;
        @(posedge ACLK); #1;
        tests_run++;
        if (AWREADY !== 1'b1 || WREADY !== 1'b0 || fifo_count !== '0) begin
            tests_failed++;
            $display("FAIL midrst_release: got aw=%b w=%b count=%0d want 1 0 0", AWREADY, WREADY, fifo_count);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            int space = DEPTH - model_q.size();
            bit do_w = (space > 0) && ($urandom_range(0, 3) != 0);
            bit do_r = ($urandom_range(0, 2) != 0);
            int wlen = do_w ? $urandom_range(0, (space - 1 < 7) ? space - 1 : 7) : 0;
            int rlen = $urandom_range(0, 7);
            logic [1:0] eb;
            fill_write(wlen);
            for (int i = 0; i <= wlen; i++) begin
                if ($urandom_range(0, 7) == 0) w_strb[i] = SW'($urandom_range(0, 14));
                if ($urandom_range(0, 15) == 0) w_last[i] = ~w_last[i];
            end
            eb = exp_bresp(wlen);
            bus_run(do_w, wlen, do_r, rlen, $urandom_range(0, 4), 25, $urandom_range(0, 3));
            tests_run++;
            if (cnt_err != 0 || (do_w && bresp_obs !== eb)) begin
                tests_failed++;
                $display("FAIL rand%0d_write: got cnt_err=%0d bresp=%b want 0 %b", it, cnt_err, bresp_obs, eb);
            end
            for (int i = 0; i < r_beats; i++) begin
                tests_run++;
                if (r_obs_data[i] !== r_exp_data[i] || r_obs_resp[i] !== r_exp_resp[i] ||
                    r_obs_last[i] !== r_exp_last[i]) begin
                    tests_failed++;
                    $display("FAIL rand%0d_rbeat%0d: got %h/%b/%b want %h/%b/%b", it, i, r_obs_data[i],
                             r_obs_resp[i], r_obs_last[i], r_exp_data[i], r_exp_resp[i], r_exp_last[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty_read();
        test_bad_write();
        test_overlap();
        test_overflow();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
